fpu_writeback: RTL and testbench

FPU_WRITEBACK -- requirements
Module: fpu_writeback

---
 rtl/fpu_writeback.sv | 160 ++++++++++++++++
 tb/tb_fpu_writeback.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_writeback.sv
// fpu_writeback: FPU/ALU result writeback stage.
//   - FPR write port: one registered BF16 write per FPU float completion.
//   - GPR write port: small FIFO merging ALU and FPU integer results,
//     up to two pushes and one pop per cycle, head presented combinationally.
//   - Optional sticky FP exception flags and invalid-op trap pulse,
//     built only when FPU_WB_FLAG_ACCUM_EN is defined; otherwise tied to 0.
module fpu_writeback #(
   parameter int GQ_DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_l,
   input  logic        fpu_complete,
   input  logic [15:0] fpu_result_1,
   input  logic [4:0]  ex_frd_addr,
   input  logic        fpu_complete_rd,
   input  logic [31:0] fpu_result_rd,
   input  logic [4:0]  ex_fpu_rd_addr,
   input  logic        Activation_Signal,
   input  logic [31:0] result,
   input  logic [4:0]  ex_alu_rd_addr,
   input  logic [4:0]  sflags,
   input  logic        IV_exception,
   input  logic        fflags_clr,
   output logic        fpr_we,
   output logic [4:0]  fpr_waddr,
   output logic [15:0] fpr_wdata,
   output logic        gpr_we,
   output logic [4:0]  gpr_waddr,
   output logic [31:0] gpr_wdata,
   output logic        wb_stall,
   output logic [4:0]  fflags,
   output logic        iv_trap,
   output logic        gq_overflow
);

   localparam int PTR_W = $clog2(GQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic             fpr_vld_p1;
   logic [4:0]       fpr_addr_p1;
   logic [15:0]      fpr_data_p1;

   logic [4:0]       addr_mem [GQ_DEPTH];
   logic [31:0]      data_mem [GQ_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_nxt1;
   logic [CNT_W-1:0] count;
   logic             overflow_q;

   logic             push_a;
   logic             push_b;
   logic             pop;
   logic [1:0]       n_req;
   logic [1:0]       n_acc;
   logic [CNT_W-1:0] free_slots;
   logic             acc0;
   logic             acc1;
   logic             drop;
   logic [4:0]       e0_addr;
   logic [31:0]      e0_data;

   // Register the FPR write port one cycle after an FPU float completion.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         fpr_vld_p1  <= 1'b0;
         fpr_addr_p1 <= '0;
         fpr_data_p1 <= '0;
      end else begin
         fpr_vld_p1 <= fpu_complete;
         if (fpu_complete) begin
            fpr_addr_p1 <= ex_frd_addr;
            fpr_data_p1 <= fpu_result_1;
         end
      end
   end

   assign fpr_we    = fpr_vld_p1;
   assign fpr_waddr = fpr_addr_p1;
   assign fpr_wdata = fpr_data_p1;

   // Decide which pushes fit; the ALU entry (if any) is always the first one.
   always_comb begin
      push_a     = Activation_Signal && (ex_alu_rd_addr != 5'd0);
      push_b     = fpu_complete_rd && (ex_fpu_rd_addr != 5'd0);
      pop        = (count != '0);
      n_req      = {1'b0, push_a} + {1'b0, push_b};
      free_slots = CNT_W'(GQ_DEPTH) - count + {{(CNT_W-1){1'b0}}, pop};
      acc0       = (n_req != 2'd0) && (free_slots >= CNT_W'(1));
      acc1       = (n_req == 2'd2) && (free_slots >= CNT_W'(2));
      drop       = ((n_req != 2'd0) && !acc0) || ((n_req == 2'd2) && !acc1);
      n_acc      = {1'b0, acc0} + {1'b0, acc1};
      e0_addr    = push_a ? ex_alu_rd_addr : ex_fpu_rd_addr;
      e0_data    = push_a ? result : fpu_result_rd;
   end

   assign wr_ptr_nxt1 = wr_ptr + PTR_W'(1);

   // Queue storage: data only, never reset; validity lives in count.
   always_ff @(posedge clk) begin
      if (acc0) begin
         addr_mem[wr_ptr] <= e0_addr;
         data_mem[wr_ptr] <= e0_data;
      end
      if (acc1) begin
         addr_mem[wr_ptr_nxt1] <= ex_fpu_rd_addr;
         data_mem[wr_ptr_nxt1] <= fpu_result_rd;
      end
   end

   // Queue control: pointers wrap naturally, count tracks pushes minus pop.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(n_acc);
         if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
         count <= count + CNT_W'(n_acc) - CNT_W'(pop);
         if (drop) overflow_q <= 1'b1;
      end
   end

   assign gpr_we      = pop;
   assign gpr_waddr   = pop ? addr_mem[rd_ptr] : 5'd0;
   assign gpr_wdata   = pop ? data_mem[rd_ptr] : 32'd0;
   assign wb_stall    = (count >= CNT_W'(GQ_DEPTH - 1));
   assign gq_overflow = overflow_q;

`ifdef FPU_WB_FLAG_ACCUM_EN
   logic [4:0] fflags_p1;
   logic       iv_trap_p1;
   logic       any_cmp;

   assign any_cmp = fpu_complete | fpu_complete_rd;

   // Sticky flag accumulation; a clear wins over history but not over new flags.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         fflags_p1  <= '0;
         iv_trap_p1 <= 1'b0;
      end else begin
         if (fflags_clr)   fflags_p1 <= any_cmp ? sflags : 5'd0;
         else if (any_cmp) fflags_p1 <= fflags_p1 | sflags;
         iv_trap_p1 <= IV_exception & any_cmp;
      end
   end

   assign fflags  = fflags_p1;
   assign iv_trap = iv_trap_p1;
`else
   logic unused_flag_inputs;
   assign unused_flag_inputs = ^{sflags, IV_exception, fflags_clr};
   assign fflags  = 5'd0;
   assign iv_trap = 1'b0;
`endif

endmodule

// File: tb/tb_fpu_writeback.sv
// Scoreboard bench for fpu_writeback (GQ_DEPTH=4).
module tb_fpu_writeback;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [4:0]  a;
      logic [31:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst_l = 1'b1;
   logic        fpu_complete = 1'b0;
   logic [15:0] fpu_result_1 = '0;
   logic [4:0]  ex_frd_addr = '0;
   logic        fpu_complete_rd = 1'b0;
   logic [31:0] fpu_result_rd = '0;
   logic [4:0]  ex_fpu_rd_addr = '0;
   logic        Activation_Signal = 1'b0;
   logic [31:0] result = '0;
   logic [4:0]  ex_alu_rd_addr = '0;
   logic [4:0]  sflags = '0;
   logic        IV_exception = 1'b0;
   logic        fflags_clr = 1'b0;
   logic        fpr_we;
   logic [4:0]  fpr_waddr;
   logic [15:0] fpr_wdata;
   logic        gpr_we;
   logic [4:0]  gpr_waddr;
   logic [31:0] gpr_wdata;
   logic        wb_stall;
   logic [4:0]  fflags;
   logic        iv_trap;
   logic        gq_overflow;

   int   n_checks = 0;
   int   n_fail = 0;
   ent_t sb[$];
   logic ov_exp = 1'b0;
   logic fpr_we_exp = 1'b0;
   logic [4:0]  fpr_addr_exp = '0;
   logic [15:0] fpr_data_exp = '0;
   logic [4:0]  ff_exp = '0;
   logic        iv_exp = 1'b0;

   fpu_writeback #(.GQ_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_l(rst_l),
      .fpu_complete(fpu_complete), .fpu_result_1(fpu_result_1), .ex_frd_addr(ex_frd_addr),
      .fpu_complete_rd(fpu_complete_rd), .fpu_result_rd(fpu_result_rd), .ex_fpu_rd_addr(ex_fpu_rd_addr),
      .Activation_Signal(Activation_Signal), .result(result), .ex_alu_rd_addr(ex_alu_rd_addr),
      .sflags(sflags), .IV_exception(IV_exception), .fflags_clr(fflags_clr),
      .fpr_we(fpr_we), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata),
      .gpr_we(gpr_we), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
      .wb_stall(wb_stall), .fflags(fflags), .iv_trap(iv_trap), .gq_overflow(gq_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      fpu_complete = 1'b0; fpu_complete_rd = 1'b0; Activation_Signal = 1'b0;
      IV_exception = 1'b0; fflags_clr = 1'b0; sflags = '0;
   endtask

   // Update the model from the driven inputs, clock once, then compare.
   task automatic tick();
      int free;
      logic cmp;
      if (sb.size() != 0) void'(sb.pop_front());
      free = DEPTH - sb.size();
      if (Activation_Signal && ex_alu_rd_addr != 5'd0) begin
         if (free > 0) begin sb.push_back({ex_alu_rd_addr, result}); free--; end
         else ov_exp = 1'b1;
      end
      if (fpu_complete_rd && ex_fpu_rd_addr != 5'd0) begin
         if (free > 0) begin sb.push_back({ex_fpu_rd_addr, fpu_result_rd}); free--; end
         else ov_exp = 1'b1;
      end
      fpr_we_exp = fpu_complete;
      if (fpu_complete) begin fpr_addr_exp = ex_frd_addr; fpr_data_exp = fpu_result_1; end
      cmp = fpu_complete | fpu_complete_rd;
`ifdef FPU_WB_FLAG_ACCUM_EN
      if (fflags_clr) ff_exp = cmp ? sflags : 5'd0;
      else if (cmp)   ff_exp = ff_exp | sflags;
      iv_exp = IV_exception & cmp;
`endif
      @(posedge clk);
      #1;
      clear_inputs();
      check("fpr_we", fpr_we, fpr_we_exp);
      if (fpr_we_exp) begin
         check("fpr_waddr", fpr_waddr, fpr_addr_exp);
         check("fpr_wdata", fpr_wdata, fpr_data_exp);
      end
      check("gpr_we", gpr_we, sb.size() != 0);
      if (sb.size() != 0) begin
         check("gpr_waddr", gpr_waddr, sb[0].a);
         check("gpr_wdata", gpr_wdata, sb[0].d);
      end
      check("wb_stall", wb_stall, sb.size() >= DEPTH - 1);
      check("gq_overflow", gq_overflow, ov_exp);
      check("fflags", fflags, ff_exp);
      check("iv_trap", iv_trap, iv_exp);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_fpr_we"}, fpr_we, 0);
      check({tag, "_fpr_waddr"}, fpr_waddr, 0);
      check({tag, "_fpr_wdata"}, fpr_wdata, 0);
      check({tag, "_gpr_we"}, gpr_we, 0);
      check({tag, "_gpr_waddr"}, gpr_waddr, 0);
      check({tag, "_gpr_wdata"}, gpr_wdata, 0);
      check({tag, "_wb_stall"}, wb_stall, 0);
      check({tag, "_fflags"}, fflags, 0);
      check({tag, "_iv_trap"}, iv_trap, 0);
      check({tag, "_gq_overflow"}, gq_overflow, 0);
   endtask

   task automatic dual(input logic [4:0] ra, input logic [31:0] da,
                       input logic [4:0] rb, input logic [31:0] db);
      Activation_Signal = 1'b1; ex_alu_rd_addr = ra; result = da;
      fpu_complete_rd = 1'b1; ex_fpu_rd_addr = rb; fpu_result_rd = db;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      #2 rst_l = 1'b0;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk);
      @(negedge clk) rst_l = 1'b1;
      tick();

      // FPR path
      fpu_complete = 1'b1; ex_frd_addr = 5'd5; fpu_result_1 = 16'h3F80;
      tick();
      check("fpr_direct_we", fpr_we, 1);
      check("fpr_direct_data", fpr_wdata, 16'h3F80);
      tick();
      check("fpr_idle_we", fpr_we, 0);
      fpu_complete = 1'b1; ex_frd_addr = 5'd0; fpu_result_1 = 16'h1234;
      tick();
      tick();

      // Dual push ordering: ALU first
      dual(5'd3, 32'h11, 5'd4, 32'h22);
      tick();
      check("dual_first_addr", gpr_waddr, 3);
      check("dual_first_data", gpr_wdata, 32'h11);
      tick();
      check("dual_second_addr", gpr_waddr, 4);
      check("dual_second_data", gpr_wdata, 32'h22);
      tick();
      check("dual_drained", gpr_we, 0);

      // x0 destination discarded on both sources
      Activation_Signal = 1'b1; ex_alu_rd_addr = 5'd0; result = 32'hDEAD;
      tick();
      check("x0_alu_we", gpr_we, 0);
      fpu_complete_rd = 1'b1; ex_fpu_rd_addr = 5'd0; fpu_result_rd = 32'hBEEF;
      tick();
      check("x0_fpu_we", gpr_we, 0);

      // Fill until a push is dropped; net +1 per cycle while popping
      for (int i = 0; i < 4; i++) begin
         dual(5'(8 + 2 * i), 32'hA000 + i, 5'(9 + 2 * i), 32'hB000 + i);
         tick();
      end
      check("ovf_sticky", gq_overflow, 1);
      check("ovf_stall", wb_stall, 1);
      for (int i = 0; i < 6; i++) tick();
      check("ovf_still_set", gq_overflow, 1);

      // Flag accumulation sequence
      fpu_complete = 1'b1; sflags = 5'b00001;
      tick();
      fpu_complete_rd = 1'b1; ex_fpu_rd_addr = 5'd0; sflags = 5'b10000;
      tick();
`ifdef FPU_WB_FLAG_ACCUM_EN
      check("fflags_accum", fflags, 5'b10001);
`endif
      fflags_clr = 1'b1; fpu_complete = 1'b1; sflags = 5'b00100;
      tick();
`ifdef FPU_WB_FLAG_ACCUM_EN
      check("fflags_clr_cmp", fflags, 5'b00100);
`endif
      IV_exception = 1'b1; fpu_complete = 1'b1;
      tick();
`ifdef FPU_WB_FLAG_ACCUM_EN
      check("iv_pulse", iv_trap, 1);
`endif
      IV_exception = 1'b1;
      tick();
      fflags_clr = 1'b1;
      tick();

      // Random traffic
      for (int i = 0; i < 60; i++) begin
         Activation_Signal = 1'($urandom_range(0, 1));
         ex_alu_rd_addr    = 5'($urandom_range(0, 31));
         result            = $urandom;
         fpu_complete_rd   = 1'($urandom_range(0, 1));
         ex_fpu_rd_addr    = 5'($urandom_range(0, 31));
         fpu_result_rd     = $urandom;
         fpu_complete      = 1'($urandom_range(0, 1));
         ex_frd_addr       = 5'($urandom_range(0, 31));
         fpu_result_1      = 16'($urandom);
         sflags            = 5'($urandom);
         IV_exception      = 1'($urandom_range(0, 1));
         fflags_clr        = ($urandom_range(0, 7) == 0);
         tick();
      end

      // Reset with three queued entries
      for (int i = 0; i < 6; i++) tick();
      dual(5'd20, 32'h2020, 5'd21, 32'h2121);
      tick();
      dual(5'd22, 32'h2222, 5'd23, 32'h2323);
      fpu_complete = 1'b1; ex_frd_addr = 5'd7; fpu_result_1 = 16'h4000;
      tick();
      check("pre_reset_stall", wb_stall, 1);
      #2 rst_l = 1'b0;
      #1 check_all_zero("midreset");
      sb.delete();
      ov_exp = 1'b0; fpr_we_exp = 1'b0; ff_exp = '0; iv_exp = 1'b0;
      @(negedge clk) rst_l = 1'b1;
      tick();
      check("post_reset_gpr_we", gpr_we, 0);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
